// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port data-memory arbiter.
//   arb_state_e   : ownership state (IDLE / OWN0 / OWN1)
//   PORT0 / PORT1 : port index constants, also the encoding of last_gnt
//   DEF_*         : default depth and burst-length limits
//   word_in_range : true when a word index falls inside the memory
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_MEM_WORDS = 64;
  localparam int DEF_MAX_BURST = 8;

  function automatic logic word_in_range(input logic [29:0]   word_idx,
                                         input int unsigned   words);
    return ({2'b00, word_idx} < words);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// ----------------------------------------------------------------------------
// arb_rr_pick
// Combinational two-way tie-break. A lone requester wins; with both
// requesting, the port that was NOT granted most recently wins.
//   i_req0, i_req1 : requests
//   i_last_gnt     : port granted most recently (PORT0 / PORT1)
//   o_gnt[1:0]     : one-hot grant, bit i = port i, all zero when idle
// ----------------------------------------------------------------------------
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      o_gnt = (i_last_gnt == PORT1) ? 2'b01 : 2'b10;
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares one combinational-read data memory between the processor data
// port (port 0) and the loader/debug port (port 1). Grants are
// combinational; read data, read-valid and range errors are registered.
// A port may hold the memory across cycles with its lock input, up to
// MAX_BURST consecutive grants, after which it must re-arbitrate.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   i_req*/i_we*/i_lock*       : request, write enable, burst lock
//   i_addr*/i_wdata*           : byte address (word aligned), write data
//   o_gnt*                     : access performed this cycle (comb)
//   o_rdata*/o_rvalid*         : read data, valid one cycle after grant
//   o_err*                     : previous granted access was out of range
//   o_stall                    : port 0 requesting but not granted (comb)
//   o_mem_we/o_mem_addr/o_mem_wd, i_mem_rd : memory side
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; grant by tie-break against last_gnt
// OWN0    | port 0 holds a lock; granted whenever i_req0 is high
// OWN1    | port 1 holds a lock; granted whenever i_req1 is high
// ----------------------------------------------------------------------------
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic        i_lock0,
  input  logic        i_lock1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic        o_err0,
  output logic        o_err1,
  output logic        o_stall,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_last_gnt;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic             r_err0;
  logic             r_err1;

  logic [1:0]       w_pick;
  logic [1:0]       w_gnt;
  logic             w_any_gnt;
  logic             w_sel_we;
  logic             w_sel_lock;
  logic [31:0]      w_sel_addr;
  logic             w_in_range;
  logic             w_owner_cont;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_burst_done;
  logic [31:0]      w_rd_data;

  arb_rr_pick u_pick (
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_pick)
  );

  // An owner with its request up bypasses the tie-break; an owner that
  // drops its request falls back to the tie-break in the same cycle.
  always_comb begin
    w_gnt = w_pick;
    if (r_state == ST_OWN0 && i_req0) begin
      w_gnt = 2'b01;
    end else if (r_state == ST_OWN1 && i_req1) begin
      w_gnt = 2'b10;
    end
    if (!rst_n) begin
      w_gnt = 2'b00;
    end
  end

  assign w_any_gnt  = |w_gnt;
  assign w_sel_we   = w_gnt[1] ? i_we1   : i_we0;
  assign w_sel_lock = w_gnt[1] ? i_lock1 : i_lock0;
  assign w_sel_addr = w_gnt[1] ? i_addr1 : i_addr0;
  assign w_in_range = word_in_range(w_sel_addr[31:2], MEM_WORDS);

  // Burst length counts every grant of the current ownership, including
  // the IDLE grant that established it.
  assign w_owner_cont = (r_state == ST_OWN0 && w_gnt[0]) ||
                        (r_state == ST_OWN1 && w_gnt[1]);
  assign w_cnt_next   = w_owner_cont ? (r_burst_cnt + CNT_W'(1)) : CNT_W'(1);
  assign w_burst_done = (w_cnt_next == CNT_W'(MAX_BURST));

  // Out-of-range reads return zero rather than whatever the memory aliases.
  assign w_rd_data = w_in_range ? i_mem_rd : 32'h0;

  assign o_gnt0     = w_gnt[0];
  assign o_gnt1     = w_gnt[1];
  assign o_stall    = i_req0 & ~w_gnt[0];
  assign o_mem_addr = w_sel_addr;
  assign o_mem_wd   = w_gnt[1] ? i_wdata1 : i_wdata0;
  assign o_mem_we   = w_any_gnt & w_sel_we & w_in_range;

  assign o_rdata0  = r_rdata0;
  assign o_rdata1  = r_rdata1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_err0    = r_err0;
  assign o_err1    = r_err1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_last_gnt  <= PORT1;
      r_rdata0    <= 32'h0;
      r_rdata1    <= 32'h0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;

      if (w_any_gnt) begin
        r_last_gnt <= w_gnt[1] ? PORT1 : PORT0;

        if (w_burst_done || !w_sel_lock) begin
          r_state     <= ST_IDLE;
          r_burst_cnt <= '0;
        end else begin
          r_state     <= w_gnt[1] ? ST_OWN1 : ST_OWN0;
          r_burst_cnt <= w_cnt_next;
        end

        if (!w_sel_we) begin
          if (w_gnt[0]) begin
            r_rdata0  <= w_rd_data;
            r_rvalid0 <= 1'b1;
          end else begin
            r_rdata1  <= w_rd_data;
            r_rvalid1 <= 1'b1;
          end
        end

        if (!w_in_range) begin
          if (w_gnt[0]) begin
            r_err0 <= 1'b1;
          end else begin
            r_err1 <= 1'b1;
          end
        end
      end else begin
        r_state     <= ST_IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

endmodule
